// File: rtl/calltrace_x_pkg.sv
// Shared constants, status word layout and helpers for the calltrace_x monitor.
package calltrace_x_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_SEL  = 2'd2;
  localparam logic [1:0] ADDR_PEEK = 2'd3;

  localparam int unsigned CTRL_CLEAR     = 1;
  localparam int unsigned CTRL_FREEZE    = 2;
  localparam int unsigned CTRL_UNFREEZE  = 3;
  localparam int unsigned CTRL_WRAP_SET  = 4;
  localparam int unsigned CTRL_WRAP_CLR  = 5;
  localparam int unsigned CTRL_FLAGS_CLR = 6;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_FROZEN    = 2;
  localparam int unsigned ST_OVERFLOW  = 3;
  localparam int unsigned ST_UNDERFLOW = 4;
  localparam int unsigned ST_WRAP      = 5;

  localparam logic [31:0] DEFAULT_PUSH_INSTR = 32'hAFE00000;
  localparam logic [31:0] DEFAULT_POP_INSTR  = 32'hC700000F;

  typedef struct packed {
    logic [7:0] max_count;
    logic [7:0] count;
    logic [7:0] stack;
    logic [7:0] flags;
  } status_t;

  function automatic status_t pack_status(
    input logic [7:0] max_count,
    input logic [7:0] count,
    input logic [7:0] stack,
    input logic       wrap,
    input logic       underflow,
    input logic       overflow,
    input logic       frozen,
    input logic       full,
    input logic       empty
  );
    status_t s;
    s = '0;
    s.max_count           = max_count;
    s.count               = count;
    s.stack               = stack;
    s.flags[ST_EMPTY]     = empty;
    s.flags[ST_FULL]      = full;
    s.flags[ST_FROZEN]    = frozen;
    s.flags[ST_OVERFLOW]  = overflow;
    s.flags[ST_UNDERFLOW] = underflow;
    s.flags[ST_WRAP]      = wrap;
    return s;
  endfunction

endpackage

// File: rtl/ct_stack_x.sv
// One return-address stack: ring storage, count, sticky flags, peek pointer.
// High-water mark is built only when CALLTRACE_X_HWM_EN is defined.
module ct_stack_x
  import calltrace_x_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 32,
  parameter int unsigned DATA_WIDTH   = 24,
  parameter bit          WRAP_DEFAULT = 1'b0,
  localparam int unsigned CNT_W       = $clog2(NUM_SLOTS) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [DATA_WIDTH-1:0]              push_val,
  input  logic                               peek_rd,
  input  logic                               cmd_valid,
  input  logic [CTRL_FLAGS_CLR:CTRL_CLEAR]   cmd,
  output logic [CNT_W-1:0]                   count,
  output logic [CNT_W-1:0]                   max_count,
  output logic                               frozen,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               wrap,
  output logic [DATA_WIDTH-1:0]              top_val,
  output logic [DATA_WIDTH-1:0]              peek_val
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [IDX_W-1:0]      wp, wp_n, top_idx, next_idx, peek_idx, mem_addr;
  logic [CNT_W-1:0]      count_n, peek_off, off_n, eff_off;
  logic [SUM_W-1:0]      pk_sum;
  logic                  frozen_n, overflow_n, underflow_n, wrap_n;
  logic                  mem_we, hwm_clr;

  // wp is the next free slot; the top entry sits just below it in the ring
  always_comb begin
    top_idx  = (wp == '0) ? IDX_W'(NUM_SLOTS - 1) : wp - IDX_W'(1);
    next_idx = (wp == IDX_W'(NUM_SLOTS - 1)) ? '0 : wp + IDX_W'(1);
    eff_off  = (peek_off >= count) ? '0 : peek_off;
    pk_sum   = SUM_W'(top_idx) + SUM_W'(NUM_SLOTS) - SUM_W'(eff_off);
    if (pk_sum >= SUM_W'(NUM_SLOTS)) pk_sum = pk_sum - SUM_W'(NUM_SLOTS);
    peek_idx = IDX_W'(pk_sum);
    top_val  = (count == '0) ? '0 : mem[top_idx];
    peek_val = (count == '0) ? '0 : mem[peek_idx];
  end

  always_comb begin
    count_n     = count;
    wp_n        = wp;
    off_n       = peek_off;
    frozen_n    = frozen;
    overflow_n  = overflow;
    underflow_n = underflow;
    wrap_n      = wrap;
    mem_we      = 1'b0;
    mem_addr    = wp;
    hwm_clr     = 1'b0;
    if (!frozen) begin
      if (push && pop && count != '0) begin
        mem_we   = 1'b1;
        mem_addr = top_idx;
      end else if (push) begin
        if (count == CNT_W'(NUM_SLOTS)) begin
          overflow_n = 1'b1;
          if (wrap) begin
            mem_we = 1'b1;
            wp_n   = next_idx;
          end
        end else begin
          mem_we  = 1'b1;
          wp_n    = next_idx;
          count_n = count + CNT_W'(1);
        end
      end else if (pop) begin
        if (count == '0) begin
          underflow_n = 1'b1;
        end else begin
          wp_n    = top_idx;
          count_n = count - CNT_W'(1);
        end
      end
    end
    if (peek_rd) off_n = (eff_off + CNT_W'(1) >= count) ? '0 : eff_off + CNT_W'(1);
    // clear goes first so the remaining command bits act on the emptied stack
    if (cmd_valid) begin
      if (cmd[CTRL_CLEAR]) begin
        count_n     = '0;
        wp_n        = '0;
        off_n       = '0;
        overflow_n  = 1'b0;
        underflow_n = 1'b0;
        hwm_clr     = 1'b1;
      end
      if (cmd[CTRL_FREEZE]) begin
        frozen_n = 1'b1;
        off_n    = '0;
      end
      if (cmd[CTRL_UNFREEZE]) begin
        frozen_n = 1'b0;
        off_n    = '0;
      end
      if (cmd[CTRL_WRAP_SET]) wrap_n = 1'b1;
      if (cmd[CTRL_WRAP_CLR]) wrap_n = 1'b0;
      if (cmd[CTRL_FLAGS_CLR]) begin
        overflow_n  = 1'b0;
        underflow_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wp        <= '0;
      peek_off  <= '0;
      frozen    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      wrap      <= WRAP_DEFAULT;
    end else begin
      count     <= count_n;
      wp        <= wp_n;
      peek_off  <= off_n;
      frozen    <= frozen_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
      wrap      <= wrap_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= push_val;
  end

`ifdef CALLTRACE_X_HWM_EN
  logic [CNT_W-1:0] hwm;
  always_ff @(posedge clk) begin
    if (rst)                  hwm <= '0;
    else if (hwm_clr)         hwm <= '0;
    else if (count_n > hwm)   hwm <= count_n;
  end
  assign max_count = hwm;
`else
  logic unused_hwm;
  assign unused_hwm = hwm_clr;
  assign max_count  = '0;
`endif

endmodule

// File: rtl/calltrace_x.sv
// Multi-process call-trace monitor: NUM_STACKS return-address stacks behind a
// 4-register bus. Optional high-water mark via CALLTRACE_X_HWM_EN.
module calltrace_x
  import calltrace_x_pkg::*;
#(
  parameter int unsigned NUM_STACKS   = 32,
  parameter int unsigned NUM_SLOTS    = 32,
  parameter int unsigned DATA_WIDTH   = 24,
  parameter logic [31:0] PUSH_INSTR   = DEFAULT_PUSH_INSTR,
  parameter logic [31:0] POP_INSTR    = DEFAULT_POP_INSTR,
  parameter bit          WRAP_DEFAULT = 1'b0,
  localparam int unsigned PID_W       = $clog2(NUM_STACKS),
  localparam int unsigned CNT_W       = $clog2(NUM_SLOTS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb,
  input  logic                  we,
  input  logic [1:0]            addr,
  input  logic [31:0]           ir_in,
  input  logic [DATA_WIDTH-1:0] lnk_in,
  input  logic [PID_W-1:0]      cp_pid,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  ack
);

  logic                  push_q, pop_q, push_hit, pop_hit;
  logic                  bus_push, rd_data, rd_peek, eff_push, eff_pop;
  logic [PID_W-1:0]      sel;
  logic [DATA_WIDTH-1:0] push_val;

  logic [CNT_W-1:0]      cnt_a  [NUM_STACKS];
  logic [CNT_W-1:0]      max_a  [NUM_STACKS];
  logic [DATA_WIDTH-1:0] top_a  [NUM_STACKS];
  logic [DATA_WIDTH-1:0] peek_a [NUM_STACKS];
  status_t               st_a   [NUM_STACKS];
  logic [NUM_STACKS-1:0] frz_v, ovf_v, unf_v, wrap_v;

  logic unused_data;
  assign unused_data = ^data_in;

  // IR triggers fire only on the first cycle of a pattern match
  always_comb begin
    push_hit = (ir_in == PUSH_INSTR);
    pop_hit  = (ir_in == POP_INSTR);
    bus_push = stb && we && (addr == ADDR_DATA);
    rd_data  = stb && !we && (addr == ADDR_DATA);
    rd_peek  = stb && !we && (addr == ADDR_PEEK);
    eff_push = bus_push || (push_hit && !push_q);
    eff_pop  = rd_data || (pop_hit && !pop_q);
    push_val = bus_push ? data_in[DATA_WIDTH-1:0] : lnk_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      sel    <= '0;
    end else begin
      push_q <= push_hit;
      pop_q  <= pop_hit;
      if (stb && we && (addr == ADDR_SEL)) sel <= data_in[PID_W-1:0];
    end
  end

  for (genvar i = 0; i < NUM_STACKS; i++) begin : g_stack
    logic hit_pid, hit_sel, hit_cmd;
    assign hit_pid = (cp_pid == PID_W'(i));
    assign hit_sel = (sel == PID_W'(i));
    assign hit_cmd = stb && we && (addr == ADDR_CTRL) && (data_in[15:8] == 8'(i));

    ct_stack_x #(
      .NUM_SLOTS    (NUM_SLOTS),
      .DATA_WIDTH   (DATA_WIDTH),
      .WRAP_DEFAULT (WRAP_DEFAULT)
    ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (eff_push && hit_pid),
      .pop       (eff_pop && hit_pid),
      .push_val  (push_val),
      .peek_rd   ((rd_data && hit_pid && frz_v[i]) || (rd_peek && hit_sel)),
      .cmd_valid (hit_cmd),
      .cmd       (data_in[CTRL_FLAGS_CLR:CTRL_CLEAR]),
      .count     (cnt_a[i]),
      .max_count (max_a[i]),
      .frozen    (frz_v[i]),
      .overflow  (ovf_v[i]),
      .underflow (unf_v[i]),
      .wrap      (wrap_v[i]),
      .top_val   (top_a[i]),
      .peek_val  (peek_a[i])
    );

    assign st_a[i] = pack_status(8'(max_a[i]), 8'(cnt_a[i]), 8'(i), wrap_v[i], unf_v[i],
                                 ovf_v[i], frz_v[i], cnt_a[i] == CNT_W'(NUM_SLOTS),
                                 cnt_a[i] == '0);
  end

  assign ack = stb;

  always_comb begin
    data_out = '0;
    if (stb && !we) begin
      case (addr)
        ADDR_DATA: data_out = frz_v[cp_pid] ? 32'(peek_a[cp_pid]) : 32'(top_a[cp_pid]);
        ADDR_CTRL: data_out = st_a[cp_pid];
        ADDR_SEL:  data_out = st_a[sel];
        ADDR_PEEK: data_out = 32'(peek_a[sel]);
        default:   data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_calltrace_x.sv
// Bench for calltrace_x: directed vector table, hand sequences and random traffic vs a stack model.
`timescale 1ns/1ps
module tb_calltrace_x;
  import calltrace_x_pkg::*;

  localparam int unsigned NS  = 8;
  localparam int unsigned NSL = 4;
  localparam int unsigned DW  = 24;
  localparam logic [31:0] PI  = 32'hAFE00000;
  localparam logic [31:0] QI  = 32'hC700000F;
  localparam logic [31:0] NI  = 32'h00000000;
`ifdef CALLTRACE_X_HWM_EN
  localparam bit HWM_ON = 1'b1;
`else
  localparam bit HWM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stb, we, ack;
  logic [1:0]    addr;
  logic [31:0]   ir_in, data_in, data_out;
  logic [DW-1:0] lnk_in;
  logic [2:0]    cp_pid;

  int checks   = 0;
  int failures = 0;

  calltrace_x #(.NUM_STACKS(NS), .NUM_SLOTS(NSL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .ir_in(ir_in),
    .lnk_in(lnk_in), .cp_pid(cp_pid), .data_in(data_in), .data_out(data_out), .ack(ack)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: index 0 is the bottom entry ----------------
  logic [DW-1:0] m_mem [NS][NSL];
  int            m_cnt [NS];
  int            m_max [NS];
  int            m_peek[NS];
  bit            m_frz [NS];
  bit            m_ovf [NS];
  bit            m_unf [NS];
  bit            m_wrap[NS];
  int            m_sel;
  bit            m_pq, m_qq;

  function automatic void model_reset();
    for (int k = 0; k < NS; k++) begin
      m_cnt[k] = 0; m_max[k] = 0; m_peek[k] = 0;
      m_frz[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_wrap[k] = 0;
    end
    m_sel = 0; m_pq = 0; m_qq = 0;
  endfunction

  function automatic logic [7:0] hm(input int x);
    return HWM_ON ? 8'(x) : 8'h00;
  endfunction

  function automatic logic [31:0] m_top(input int s);
    return (m_cnt[s] == 0) ? 32'h0 : 32'(m_mem[s][m_cnt[s]-1]);
  endfunction

  function automatic logic [31:0] m_peek_entry(input int s);
    int o;
    if (m_cnt[s] == 0) return 32'h0;
    o = (m_peek[s] >= m_cnt[s]) ? 0 : m_peek[s];
    return 32'(m_mem[s][m_cnt[s]-1-o]);
  endfunction

  function automatic void m_adv(input int s);
    int o;
    o = (m_peek[s] >= m_cnt[s]) ? 0 : m_peek[s];
    m_peek[s] = (o + 1 >= m_cnt[s]) ? 0 : o + 1;
  endfunction

  function automatic logic [31:0] m_status(input int s);
    logic [7:0] f;
    f = {2'b00, m_wrap[s], m_unf[s], m_ovf[s], m_frz[s], m_cnt[s] == NSL, m_cnt[s] == 0};
    return {hm(m_max[s]), 8'(m_cnt[s]), 8'(s), f};
  endfunction

  function automatic logic [31:0] model_read(input logic s, w, input logic [1:0] a, input logic [2:0] p);
    if (!s || w) return 32'h0;
    case (a)
      2'd0:    return m_frz[p] ? m_peek_entry(int'(p)) : m_top(int'(p));
      2'd1:    return m_status(int'(p));
      2'd2:    return m_status(m_sel);
      default: return m_peek_entry(m_sel);
    endcase
  endfunction

  function automatic void model_step(input logic s, w, input logic [1:0] a, input logic [31:0] ir,
                                     input logic [DW-1:0] l, input logic [2:0] pp, input logic [31:0] d);
    bit bpush, push, pop;
    logic [DW-1:0] val;
    int p, t;
    p     = int'(pp);
    bpush = s && w && (a == 2'd0);
    push  = bpush || (ir == PI && !m_pq);
    pop   = (s && !w && a == 2'd0) || (ir == QI && !m_qq);
    val   = bpush ? d[DW-1:0] : l;
    if (s && !w && a == 2'd0 && m_frz[p]) m_adv(p);
    if (s && !w && a == 2'd3) m_adv(m_sel);
    if (!m_frz[p]) begin
      if (push && pop && m_cnt[p] > 0) m_mem[p][m_cnt[p]-1] = val;
      else if (push) begin
        if (m_cnt[p] == NSL) begin
          m_ovf[p] = 1;
          if (m_wrap[p]) begin
            for (int k = 0; k < NSL - 1; k++) m_mem[p][k] = m_mem[p][k+1];
            m_mem[p][NSL-1] = val;
          end
        end else begin
          m_mem[p][m_cnt[p]] = val;
          m_cnt[p]++;
        end
      end else if (pop) begin
        if (m_cnt[p] == 0) m_unf[p] = 1;
        else m_cnt[p]--;
      end
    end
    for (int k = 0; k < NS; k++) if (m_cnt[k] > m_max[k]) m_max[k] = m_cnt[k];
    if (s && w && a == 2'd1) begin
      t = int'(d[15:8]);
      if (t < NS) begin
        if (d[1]) begin m_cnt[t] = 0; m_peek[t] = 0; m_ovf[t] = 0; m_unf[t] = 0; m_max[t] = 0; end
        if (d[2]) begin m_frz[t] = 1; m_peek[t] = 0; end
        if (d[3]) begin m_frz[t] = 0; m_peek[t] = 0; end
        if (d[4]) m_wrap[t] = 1;
        if (d[5]) m_wrap[t] = 0;
        if (d[6]) begin m_ovf[t] = 0; m_unf[t] = 0; end
      end
    end
    if (s && w && a == 2'd2) m_sel = int'(d[2:0]);
    m_pq = (ir == PI);
    m_qq = (ir == QI);
  endfunction

  // ---------------- drive / compare ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic s, w, input logic [1:0] a, input logic [31:0] ir,
                     input logic [DW-1:0] l, input logic [2:0] p, input logic [31:0] d,
                     input string nm, input bit chk, input logic [31:0] exp);
    @(negedge clk);
    stb = s; we = w; addr = a; ir_in = ir; lnk_in = l; cp_pid = p; data_in = d;
    #1;
    check({nm, "_model"}, data_out, model_read(s, w, a, p));
    check({nm, "_ack"}, {31'b0, ack}, {31'b0, s});
    if (chk) check(nm, data_out, exp);
    @(posedge clk);
    model_step(s, w, a, ir, l, p, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] p, input logic [31:0] d);
    cyc(1, 1, a, NI, '0, p, d, "wr", 0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [2:0] p, input string nm, input logic [31:0] exp);
    cyc(1, 0, a, NI, '0, p, 32'h0, nm, 1, exp);
  endtask

  typedef struct {
    logic          stb, we;
    logic [1:0]    addr;
    logic [31:0]   ir;
    logic [DW-1:0] lnk;
    logic [2:0]    pid;
    logic [31:0]   din;
    logic [31:0]   exp;
  } vec_t;

  function automatic vec_t mkv(input logic s, w, input logic [1:0] a, input logic [31:0] ir,
                               input logic [DW-1:0] l, input logic [2:0] p, input logic [31:0] d,
                               input logic [31:0] e);
    vec_t v;
    v.stb = s; v.we = w; v.addr = a; v.ir = ir; v.lnk = l; v.pid = p; v.din = d; v.exp = e;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    tbl[0]  = mkv(0, 0, 0, NI, 24'h0,     0, 0, 32'h0);
    tbl[1]  = mkv(1, 0, 1, NI, 24'h0,     0, 0, 32'h00000001);
    tbl[2]  = mkv(1, 0, 2, NI, 24'h0,     0, 0, 32'h00000001);
    tbl[3]  = mkv(0, 0, 0, PI, 24'h000100, 5, 0, 32'h0);
    tbl[4]  = mkv(0, 0, 0, NI, 24'h0,     5, 0, 32'h0);
    tbl[5]  = mkv(0, 0, 0, PI, 24'h000200, 5, 0, 32'h0);
    tbl[6]  = mkv(0, 0, 0, NI, 24'h0,     5, 0, 32'h0);
    tbl[7]  = mkv(0, 0, 0, PI, 24'h000300, 5, 0, 32'h0);
    tbl[8]  = mkv(1, 0, 1, NI, 24'h0,     5, 0, {hm(3), 8'h03, 8'h05, 8'h00});
    tbl[9]  = mkv(1, 0, 0, NI, 24'h0,     5, 0, 32'h00000300);
    tbl[10] = mkv(1, 0, 1, NI, 24'h0,     5, 0, {hm(3), 8'h02, 8'h05, 8'h00});
    tbl[11] = mkv(0, 0, 0, PI, 24'h000111, 6, 0, 32'h0);
    tbl[12] = mkv(0, 0, 0, PI, 24'h000111, 6, 0, 32'h0);
    tbl[13] = mkv(0, 0, 0, PI, 24'h000111, 6, 0, 32'h0);
    tbl[14] = mkv(0, 0, 0, PI, 24'h000111, 6, 0, 32'h0);
    tbl[15] = mkv(1, 0, 1, NI, 24'h0,     6, 0, {hm(1), 8'h01, 8'h06, 8'h00});
    tbl[16] = mkv(1, 0, 0, NI, 24'h0,     2, 0, 32'h0);
    tbl[17] = mkv(1, 0, 1, NI, 24'h0,     2, 0, 32'h00000211);
    tbl[18] = mkv(1, 1, 1, NI, 24'h0,     0, 32'h00000240, 32'h0);
    tbl[19] = mkv(1, 0, 1, NI, 24'h0,     2, 0, 32'h00000201);

    rst = 1'b1; stb = 0; we = 0; addr = 0; ir_in = 0; lnk_in = 0; cp_pid = 0; data_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 20; i++)
      cyc(tbl[i].stb, tbl[i].we, tbl[i].addr, tbl[i].ir, tbl[i].lnk, tbl[i].pid, tbl[i].din,
          $sformatf("tbl%0d", i), 1, tbl[i].exp);

    // overflow without wrap, then ring overwrite with wrap on stack 3
    wr(0, 3, 32'h11); wr(0, 3, 32'h22); wr(0, 3, 32'h33); wr(0, 3, 32'h44); wr(0, 3, 32'h55);
    rd(1, 3, "ovf_status", {hm(4), 8'h04, 8'h03, 8'h0A});
    wr(1, 0, 32'h00000310);
    wr(0, 3, 32'hAA);
    rd(1, 3, "wrap_status", {hm(4), 8'h04, 8'h03, 8'h2A});
    rd(0, 3, "wrap_pop0", 32'hAA);
    rd(0, 3, "wrap_pop1", 32'h44);
    rd(0, 3, "wrap_pop2", 32'h33);
    rd(0, 3, "wrap_pop3", 32'h22);
    rd(0, 3, "wrap_pop_empty", 32'h0);
    rd(1, 3, "sticky_status", {hm(4), 8'h00, 8'h03, 8'h39});
    wr(1, 0, 32'h00000322);
    rd(1, 3, "clear_status", 32'h00000301);

    // freeze stack 7 and walk it with peek reads
    wr(0, 7, 32'hA1); wr(0, 7, 32'hB2); wr(0, 7, 32'hC3);
    wr(1, 0, 32'h00000704);
    wr(2, 0, 32'h00000007);
    rd(3, 0, "peek0", 32'hC3);
    rd(3, 0, "peek1", 32'hB2);
    rd(3, 0, "peek2", 32'hA1);
    rd(3, 0, "peek3", 32'hC3);
    cyc(0, 0, 0, QI, '0, 7, 0, "frozen_irpop", 0, 32'h0);
    cyc(0, 0, 0, NI, '0, 7, 0, "idle", 0, 32'h0);
    rd(2, 0, "frozen_status", {hm(3), 8'h03, 8'h07, 8'h04});
    rd(0, 7, "frozen_data_rd", 32'hB2);
    wr(1, 0, 32'h00000708);
    rd(0, 7, "unfrozen_pop", 32'hC3);
    rd(1, 7, "unfrozen_status", {hm(3), 8'h02, 8'h07, 8'h00});

    // bus push and IR pop together replace the top entry
    wr(0, 4, 32'h10); wr(0, 4, 32'h20);
    cyc(1, 1, 0, QI, '0, 4, 32'h77, "push_pop", 0, 32'h0);
    rd(1, 4, "pp_status", {hm(2), 8'h02, 8'h04, 8'h00});
    rd(0, 4, "pp_pop0", 32'h77);
    rd(0, 4, "pp_pop1", 32'h10);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic          s, w;
      logic [1:0]    a;
      logic [31:0]   ir, d;
      logic [DW-1:0] l;
      logic [2:0]    p;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ir = PI;
        1: ir = QI;
        2: ir = NI;
        default: ir = $urandom;
      endcase
      l = DW'($urandom);
      p = 3'($urandom);
      d = $urandom;
      if (a == 2'd1) d = {16'h0, 8'($urandom_range(0, 9)), 8'($urandom & 32'h7E)};
      cyc(s, w, a, ir, l, p, d, "rand", 0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
